// File: rtl/sat_clause_loader.sv
// Streams clause literals into a clause array: clears every row, then packs each
// clause into one row write, flagging malformed literals, overlong clauses and overflow.
module sat_clause_loader #(
  parameter int NUM_ROWS     = 32,
  parameter int COLS_PER_ROW = 4,
  parameter int NUM_VARS     = 16,
  parameter int LIT_WIDTH    = $clog2(2*NUM_VARS+2)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              lit_valid,
  input  logic [LIT_WIDTH-1:0]              lit_data,
  input  logic                              lit_last,
  input  logic                              fml_last,
  output logic                              lit_ready,
  output logic                              row_we,
  output logic [$clog2(NUM_ROWS)-1:0]       row_addr,
  output logic [COLS_PER_ROW*LIT_WIDTH-1:0] row_data,
  output logic [COLS_PER_ROW-1:0]           row_mask,
  output logic [$clog2(NUM_ROWS):0]         num_rows,
  output logic                              load_done,
  output logic                              load_err,
  output logic [1:0]                        err_code
);

  localparam int ADDR_W = $clog2(NUM_ROWS);
  localparam int NR_W   = ADDR_W + 1;
  localparam int COL_W  = (COLS_PER_ROW > 1) ? $clog2(COLS_PER_ROW) : 1;

  typedef logic [COLS_PER_ROW*LIT_WIDTH-1:0] row_t;
  typedef logic [COLS_PER_ROW-1:0]           row_mask_t;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WRITE, DONE, ERROR} state_t;

  localparam logic [1:0] ERR_BAD_LIT  = 2'd1;
  localparam logic [1:0] ERR_TOO_LONG = 2'd2;
  localparam logic [1:0] ERR_TOO_MANY = 2'd3;

  state_t     state;
  row_t       stage_data;
  row_mask_t  stage_mask;
  logic [COL_W-1:0] col;
  logic       fml_p;
  row_t       stage_data_nxt;
  row_mask_t  stage_mask_nxt;

  // Variable 0 is reserved, so literal values 0 and 1 never name a real variable.
  function automatic logic lit_bad(input logic [LIT_WIDTH-1:0] lit);
    return (lit < LIT_WIDTH'(2)) ||
           (lit[LIT_WIDTH-1:1] > (LIT_WIDTH-1)'(NUM_VARS));
  endfunction

  always_comb begin
    stage_data_nxt = stage_data;
    stage_mask_nxt = stage_mask;
    stage_data_nxt[col*LIT_WIDTH +: LIT_WIDTH] = lit_data;
    stage_mask_nxt[col] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lit_ready  <= 1'b0;
      row_we     <= 1'b0;
      row_addr   <= '0;
      row_data   <= '0;
      row_mask   <= '0;
      num_rows   <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      err_code   <= 2'd0;
      stage_data <= '0;
      stage_mask <= '0;
      col        <= '0;
      fml_p      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= CLEAR;
            num_rows   <= '0;
            col        <= '0;
            err_code   <= 2'd0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            stage_data <= '0;
            stage_mask <= '0;
            fml_p      <= 1'b0;
            row_we     <= 1'b1;
            row_addr   <= '0;
            row_data   <= '0;
            row_mask   <= '0;
          end
        end
        CLEAR: begin
          if (row_addr == ADDR_W'(NUM_ROWS-1)) begin
            row_we    <= 1'b0;
            row_addr  <= '0;
            lit_ready <= 1'b1;
            state     <= LOAD;
          end else begin
            row_addr <= row_addr + ADDR_W'(1);
          end
        end
        LOAD: begin
          if (lit_valid && lit_ready) begin
            // Error precedence: bad literal, then array full, then clause overrun.
            if (lit_bad(lit_data)) begin
              err_code  <= ERR_BAD_LIT;
              load_err  <= 1'b1;
              lit_ready <= 1'b0;
              state     <= ERROR;
            end else if (num_rows == NR_W'(NUM_ROWS)) begin
              err_code  <= ERR_TOO_MANY;
              load_err  <= 1'b1;
              lit_ready <= 1'b0;
              state     <= ERROR;
            end else if ((col == COL_W'(COLS_PER_ROW-1)) && !lit_last) begin
              err_code  <= ERR_TOO_LONG;
              load_err  <= 1'b1;
              lit_ready <= 1'b0;
              state     <= ERROR;
            end else if (lit_last) begin
              row_we    <= 1'b1;
              row_addr  <= num_rows[ADDR_W-1:0];
              row_data  <= stage_data_nxt;
              row_mask  <= stage_mask_nxt;
              fml_p     <= fml_last;
              lit_ready <= 1'b0;
              state     <= WRITE;
            end else begin
              stage_data <= stage_data_nxt;
              stage_mask <= stage_mask_nxt;
              col        <= col + COL_W'(1);
            end
          end
        end
        WRITE: begin
          row_we     <= 1'b0;
          row_addr   <= '0;
          row_data   <= '0;
          row_mask   <= '0;
          num_rows   <= num_rows + NR_W'(1);
          stage_data <= '0;
          stage_mask <= '0;
          col        <= '0;
          if (fml_p) begin
            load_done <= 1'b1;
            state     <= DONE;
          end else begin
            lit_ready <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_clause_loader.sv
// Randomized bench for sat_clause_loader: clause rows are predicted from the
// literal lists sent, and every observed row write is compared against them.
module tb_sat_clause_loader;

  localparam int NR = 32;
  localparam int NC = 4;
  localparam int NV = 16;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          lit_valid = 1'b0;
  logic [LW-1:0] lit_data = '0;
  logic          lit_last = 1'b0;
  logic          fml_last = 1'b0;
  logic          lit_ready;
  logic          row_we;
  logic [4:0]    row_addr;
  logic [23:0]   row_data;
  logic [3:0]    row_mask;
  logic [5:0]    num_rows;
  logic          load_done;
  logic          load_err;
  logic [1:0]    err_code;

  int checks = 0;
  int errors = 0;

  logic [4:0]  wa_q[$];
  logic [23:0] wd_q[$];
  logic [3:0]  wm_q[$];
  int          ex_d[$];
  int          ex_m[$];

  always #5 clk = ~clk;

  sat_clause_loader #(.NUM_ROWS(NR), .COLS_PER_ROW(NC), .NUM_VARS(NV), .LIT_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lit_valid(lit_valid), .lit_data(lit_data),
    .lit_last(lit_last), .fml_last(fml_last), .lit_ready(lit_ready), .row_we(row_we),
    .row_addr(row_addr), .row_data(row_data), .row_mask(row_mask), .num_rows(num_rows),
    .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );

  always @(negedge clk) begin
    if (row_we) begin
      wa_q.push_back(row_addr);
      wd_q.push_back(row_data);
      wm_q.push_back(row_mask);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({lit_ready, row_we, load_done, load_err, err_code, num_rows, row_addr}), 32'd0);
    chk({tag, "_row"}, 32'({row_mask, row_data}), 32'd0);
  endtask

  task automatic flush_all();
    wa_q.delete(); wd_q.delete(); wm_q.delete();
    ex_d.delete(); ex_m.delete();
  endtask

  // Called at a negedge; returns at the negedge where LOAD has begun.
  task automatic do_start();
    int n;
    flush_all();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_flags", 32'({load_done, load_err, err_code, num_rows}), 32'd0);
    n = 1;
    while (!lit_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("clr_cycles", 32'(n), 32'(NR + 1));
    chk("clr_cnt", 32'(wa_q.size()), 32'(NR));
    for (int i = 0; i < wa_q.size(); i++) begin
      chk("clr_addr", 32'(wa_q[i]), 32'(i));
      chk("clr_data", 32'({wm_q[i], wd_q[i]}), 32'd0);
    end
    wa_q.delete(); wd_q.delete(); wm_q.delete();
  endtask

  // Presents one literal after `gap` idle cycles; returns at the negedge after acceptance.
  task automatic send(input int lit, input bit last, input bit fml, input int gap);
    int n;
    lit_valid = 1'b0;
    repeat (gap) @(negedge clk);
    n = 0;
    while (!lit_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!lit_ready) chk("rdy_timeout", 32'd0, 32'd1);
    lit_valid = 1'b1;
    lit_data  = LW'(lit);
    lit_last  = last;
    fml_last  = fml;
    @(negedge clk);
    lit_valid = 1'b0;
    lit_data  = '0;
    lit_last  = 1'b0;
    fml_last  = 1'b0;
  endtask

  // Sends a well-formed clause and records the row it must produce.
  task automatic send_clause(input int l0, input int l1, input int l2, input int l3,
                             input int len, input bit fml, input int gap_max);
    int lits[4];
    int d, m;
    bit last;
    lits = '{l0, l1, l2, l3};
    d = 0;
    m = 0;
    for (int c = 0; c < len; c++) begin
      d += lits[c] << (LW * c);
      m += 1 << c;
      last = (c == len - 1);
      send(lits[c], last, last ? fml : bit'($urandom_range(0, 1)), $urandom_range(0, gap_max));
    end
    chk("wr_lat", 32'(row_we), 32'd1);
    chk("wr_rdy", 32'(lit_ready), 32'd0);
    chk("wr_addr", 32'(row_addr), 32'(ex_d.size()));
    ex_d.push_back(d);
    ex_m.push_back(m);
  endtask

  task automatic check_rows(input string tag);
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(ex_d.size()));
    for (int i = 0; i < wa_q.size() && i < ex_d.size(); i++) begin
      chk({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
      chk({tag, "_data"}, 32'(wd_q[i]), 32'(ex_d[i]));
      chk({tag, "_mask"}, 32'(wm_q[i]), 32'(ex_m[i]));
    end
  endtask

  task automatic check_end(input string tag, input int done, input int err, input int code, input int nr);
    chk({tag, "_done"}, 32'(load_done), 32'(done));
    chk({tag, "_err"}, 32'(load_err), 32'(err));
    chk({tag, "_code"}, 32'(err_code), 32'(code));
    chk({tag, "_nrows"}, 32'(num_rows), 32'(nr));
    chk({tag, "_idle"}, 32'({row_we, lit_ready}), 32'd0);
  endtask

  function automatic int good_lit();
    return $urandom_range(2, 2 * NV + 1);
  endfunction

  function automatic int bad_lit();
    return ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1) : $urandom_range(2 * NV + 2, 63);
  endfunction

  initial begin
    int bad, n, len;
    #1;
    chk_zero_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_hold", 32'({lit_ready, row_we}), 32'd0);
    chk("idle_nwr", 32'(wa_q.size()), 32'd0);

    // Directed clause (3,4,9) closing the formula.
    do_start();
    send_clause(3, 4, 9, 0, 3, 1'b1, 0);
    repeat (2) @(negedge clk);
    check_rows("dir");
    check_end("dir", 1, 0, 0, 1);
    repeat (5) @(negedge clk);
    chk("done_hold", 32'(load_done), 32'd1);

    // Malformed literals, including both edges of the legal range.
    for (int t = 0; t < 4; t++) begin
      bad = (t == 0) ? 34 : (t == 1) ? 1 : bad_lit();
      do_start();
      send(bad, 1'b1, 1'b1, $urandom_range(0, 2));
      repeat (2) @(negedge clk);
      check_rows("bad");
      check_end("bad", 0, 1, 1, 0);
    end

    // Overlong clause after one good clause.
    do_start();
    send_clause(good_lit(), good_lit(), 0, 0, 2, 1'b0, 1);
    for (int c = 0; c < 4; c++) send(good_lit(), 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    check_rows("long");
    check_end("long", 0, 1, 2, 1);

    // Bad literal in the last column outranks the overrun.
    do_start();
    for (int c = 0; c < 3; c++) send(good_lit(), 1'b0, 1'b0, 0);
    send(bad_lit(), 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    check_end("pri12", 0, 1, 1, 0);

    // Fill the array, then one more literal (good, then bad).
    for (int t = 0; t < 2; t++) begin
      do_start();
      for (int k = 0; k < NR; k++) send_clause(good_lit(), 0, 0, 0, 1, 1'b0, 0);
      send((t == 0) ? good_lit() : bad_lit(), 1'b1, 1'b0, 1);
      repeat (2) @(negedge clk);
      check_rows("full");
      check_end("full", 0, 1, (t == 0) ? 3 : 1, NR);
    end

    // Random formulas with stalls, stray fml_last and an ignored start mid-load.
    for (int t = 0; t < 6; t++) begin
      do_start();
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        len = $urandom_range(1, NC);
        send_clause(good_lit(), good_lit(), good_lit(), good_lit(), len, k == n - 1, 3);
        if (k == 0) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      repeat (2) @(negedge clk);
      check_rows("rnd");
      check_end("rnd", 1, 0, 0, n);
    end

    // Reset asserted while a row write is on the bus.
    do_start();
    send_clause(good_lit(), good_lit(), 0, 0, 2, 1'b1, 0);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("rst_wr");
    flush_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'({lit_ready, row_we, load_done}), 32'd0);
    chk("post_rst_nwr", 32'(wa_q.size()), 32'd0);
    do_start();
    send_clause(good_lit(), good_lit(), good_lit(), 0, 3, 1'b1, 1);
    repeat (2) @(negedge clk);
    check_rows("post_rst");
    check_end("post_rst", 1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
